// File: rtl/gdl_psnm.sv
// gdl_psnm: per-bit prescaled FTD trigger with single-trigger FSM, dead time and accepted-trigger counter
module gdl_psnm #(
  parameter int NBIT     = 13,
  parameter int PSW      = 8,
  parameter int DEADTIME = 8,
  parameter int CNTW     = 32
) (
  input  logic                gclk2,
  input  logic                rstn,
  input  logic [NBIT-1:0]     ftd_in,
  input  logic [NBIT-1:0]     mask,
  input  logic [NBIT*PSW-1:0] prescale,
  input  logic                busy_in,
  output logic                l1_trg,
  output logic [NBIT-1:0]     l1_type,
  output logic [CNTW-1:0]     l1_cnt,
  output logic                l1_busy
);
  localparam logic [1:0] IDLE = 2'd0, FIRE = 2'd1, DEAD = 2'd2;
  localparam int DW = $clog2(DEADTIME + 1);
  logic [1:0]      state;
  logic [DW-1:0]   dead;
  logic [NBIT-1:0] ftd_q, ftd_qq, rise, hit, psnm;
  logic            live;
  assign rise = ftd_q & ~ftd_qq;
  assign live = (state == IDLE) && !busy_in;
  // pc >= prescale-1 is the same as pc+1 >= prescale without overflowing PSW bits
  for (genvar i = 0; i < NBIT; i++) begin : g_bit
    logic [PSW-1:0] pc, ps;
    logic           adv;
    assign ps     = prescale[i*PSW +: PSW];
    assign adv    = live & rise[i] & mask[i] & (ps != '0);
    assign hit[i] = adv & (pc >= ps - PSW'(1));
    always_ff @(posedge gclk2 or negedge rstn)
      if (!rstn) pc <= '0;
      else if (adv) pc <= hit[i] ? '0 : pc + PSW'(1);
  end
  always_ff @(posedge gclk2 or negedge rstn) begin
    if (!rstn) begin
      ftd_q   <= '0;
      ftd_qq  <= '0;
      psnm    <= '0;
      state   <= IDLE;
      dead    <= '0;
      l1_trg  <= 1'b0;
      l1_type <= '0;
      l1_cnt  <= '0;
      l1_busy <= 1'b0;
    end else begin
      ftd_q   <= ftd_in;
      ftd_qq  <= ftd_q;
      psnm    <= hit;
      l1_trg  <= state == FIRE;
      l1_busy <= (state != IDLE) || busy_in;
      if (state == IDLE && psnm != '0 && !busy_in) begin
        state   <= FIRE;
        l1_type <= psnm;
      end else if (state == FIRE) begin
        state  <= DEAD;
        dead   <= DW'(DEADTIME - 1);
        l1_cnt <= l1_cnt + CNTW'(1);
      end else if (state == DEAD) begin
        if (dead != '0) dead <= dead - DW'(1);
        else if (!busy_in) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_gdl_psnm.sv
// tb_gdl_psnm: directed stimulus, cycle-level reference model compared every cycle, plus literal spot checks
module tb_gdl_psnm;
  localparam int NB = 13, PW = 8, DT = 8, CW = 4;
  logic                gclk2 = 1'b0;
  logic                rstn = 1'b0;
  logic [NB-1:0]       ftd_in = '0;
  logic [NB-1:0]       mask = '1;
  logic [NB*PW-1:0]    prescale = {NB{PW'(1)}};
  logic                busy_in = 1'b0;
  logic                l1_trg;
  logic [NB-1:0]       l1_type;
  logic [CW-1:0]       l1_cnt;
  logic                l1_busy;
  int checks = 0, errors = 0, trg_seen = 0;
  bit run = 0;

  gdl_psnm #(.NBIT(NB), .PSW(PW), .DEADTIME(DT), .CNTW(CW)) dut (
    .gclk2(gclk2), .rstn(rstn), .ftd_in(ftd_in), .mask(mask), .prescale(prescale),
    .busy_in(busy_in), .l1_trg(l1_trg), .l1_type(l1_type), .l1_cnt(l1_cnt), .l1_busy(l1_busy)
  );

  always #5 gclk2 = ~gclk2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: integer prescale counts, and the block is "idle" except from the
  // accepting edge until DEADTIME+1 edges later (extended while busy_in is held).
  bit            m_idle, m_fire, m_trg, m_busy;
  int            m_exit, m_cnt, t;
  int            m_pc[NB];
  logic [NB-1:0] m_psnm, m_s1, m_s2, m_type;

  function automatic int ps(input int i);
    return int'(prescale[i*PW +: PW]);
  endfunction

  task automatic model_reset();
    m_idle = 1; m_fire = 0; m_trg = 0; m_busy = 0; m_exit = 0; m_cnt = 0; t = 0;
    m_psnm = '0; m_s1 = '0; m_s2 = '0; m_type = '0;
    for (int i = 0; i < NB; i++) m_pc[i] = 0;
  endtask

  task automatic model_step();
    bit            live, nfire;
    logic [NB-1:0] r, np;
    t++;
    live = m_idle && !busy_in;
    r = m_s1 & ~m_s2;
    np = '0;
    for (int i = 0; i < NB; i++)
      if (live && r[i] && mask[i] && ps(i) != 0) begin
        if (m_pc[i] + 1 >= ps(i)) begin np[i] = 1'b1; m_pc[i] = 0; end
        else m_pc[i]++;
      end
    m_busy = !m_idle || busy_in;
    m_trg = m_fire;
    if (m_fire) m_cnt = (m_cnt + 1) % (1 << CW);
    nfire = 0;
    if (m_idle && m_psnm != '0 && !busy_in) begin
      nfire = 1; m_idle = 0; m_type = m_psnm; m_exit = t + DT + 1;
    end else if (!m_idle && !m_fire && t >= m_exit && !busy_in) m_idle = 1;
    m_fire = nfire;
    m_psnm = np;
    m_s2 = m_s1;
    m_s1 = ftd_in;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge gclk2 or negedge rstn);
      if (!rstn) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(negedge gclk2);
    if (run && rstn === 1'b1) begin
      chk("cyc_trg", l1_trg, m_trg);
      chk("cyc_type", l1_type, m_type);
      chk("cyc_cnt", l1_cnt, m_cnt);
      chk("cyc_busy", l1_busy, m_busy);
    end
  end

  initial forever begin
    @(posedge gclk2);
    #1;
    if (l1_trg === 1'b1) trg_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge gclk2);
  endtask

  task automatic pulse(input logic [NB-1:0] v);
    ftd_in = v;
    tick(1);
    ftd_in = '0;
  endtask

  task automatic set_ps(input int i, input int v);
    prescale[i*PW +: PW] = PW'(v);
  endtask

  initial begin
    int b;
    tick(3);
    chk("rst_trg", l1_trg, 0);
    chk("rst_type", l1_type, 0);
    chk("rst_cnt", l1_cnt, 0);
    chk("rst_busy", l1_busy, 0);
    rstn = 1'b1;
    run = 1;
    tick(2);
    // single edge, latency and type
    pulse(13'h0004);
    tick(2);
    chk("lat_early", l1_trg, 0);
    tick(1);
    chk("lat_trg", l1_trg, 1);
    chk("lat_type", l1_type, 13'h0004);
    chk("lat_cnt", l1_cnt, 1);
    tick(1);
    chk("lat_one_cycle", l1_trg, 0);
    tick(15);
    // prescale 3 on bit 4
    set_ps(4, 3);
    for (int k = 1; k <= 6; k++) begin
      b = trg_seen;
      pulse(13'h0010);
      tick(19);
      chk("ps3_edge", trg_seen - b, (k % 3 == 0) ? 1 : 0);
    end
    chk("ps3_cnt", l1_cnt, 3);
    chk("ps3_type", l1_type, 13'h0010);
    set_ps(4, 1);
    // dead time drops the edge at cycle 4
    b = trg_seen;
    pulse(13'h0001);
    tick(3);
    pulse(13'h0001);
    tick(11);
    pulse(13'h0001);
    tick(15);
    chk("dead_trgs", trg_seen - b, 2);
    chk("dead_cnt", l1_cnt, 5);
    // busy blocks counting
    set_ps(1, 2);
    busy_in = 1'b1;
    b = trg_seen;
    for (int k = 0; k < 10; k++) begin
      pulse(13'h0002);
      tick(3);
    end
    chk("busy_trgs", trg_seen - b, 0);
    chk("busy_flag", l1_busy, 1);
    busy_in = 1'b0;
    tick(3);
    chk("busy_release", l1_busy, 0);
    pulse(13'h0002);
    tick(15);
    chk("busy_first_edge", trg_seen - b, 0);
    pulse(13'h0002);
    tick(15);
    chk("busy_second_edge", trg_seen - b, 1);
    chk("busy_type", l1_type, 13'h0002);
    chk("busy_cnt", l1_cnt, 6);
    set_ps(1, 1);
    // masked bit never fires
    mask[3] = 1'b0;
    b = trg_seen;
    pulse(13'h0008);
    tick(15);
    chk("mask_trgs", trg_seen - b, 0);
    mask = '1;
    // asynchronous reset during dead time
    pulse(13'h0001);
    tick(7);
    chk("pre_rst_busy", l1_busy, 1);
    chk("pre_rst_cnt", l1_cnt, 7);
    #2 rstn = 1'b0;
    #1;
    chk("arst_trg", l1_trg, 0);
    chk("arst_type", l1_type, 0);
    chk("arst_cnt", l1_cnt, 0);
    chk("arst_busy", l1_busy, 0);
    tick(2);
    rstn = 1'b1;
    tick(2);
    b = trg_seen;
    pulse(13'h0001);
    tick(15);
    chk("post_rst_trg", trg_seen - b, 1);
    chk("post_rst_cnt", l1_cnt, 1);
    // several bits at once give one trigger
    b = trg_seen;
    pulse(13'h1A01);
    tick(15);
    chk("multi_trgs", trg_seen - b, 1);
    chk("multi_type", l1_type, 13'h1A01);
    chk("multi_cnt", l1_cnt, 2);
    // counter wrap with CNTW=4
    for (int k = 3; k <= 17; k++) begin
      pulse(NB'(1) << (k % NB));
      tick(14);
      chk("wrap_cnt", l1_cnt, k % 16);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gdl_psnm.md
GDL_PSNM -- requirements
Module: gdl_psnm

Interface
REQ-001 Parameter NBIT, default 13, number of FTD output bits received.
REQ-002 Parameter PSW, default 8, width of each per-bit prescale factor.
REQ-003 Parameter DEADTIME, default 8, number of clock cycles the block spends in DEAD after each trigger.
REQ-004 Parameter CNTW, default 32, width of the accepted-trigger counter.
REQ-005 gclk2  in  1  system clock; all logic on its rising edge; single clock domain.
REQ-006 rstn  in  1  reset, asynchronous assert, active-low.
REQ-007 ftd_in  in  NBIT  FTD output bits (bit i = FTD output i: zzx, ffs, ... bg), level signals.
REQ-008 mask  in  NBIT  per-bit enable; 1 = bit may trigger; quasi-static.
REQ-009 prescale  in  NBIT*PSW  factor for bit i in [i*PSW +: PSW]; quasi-static.
REQ-010 busy_in  in  1  downstream DAQ busy; 1 = no trigger accepted.
REQ-011 l1_trg  out  1  one-cycle accepted-trigger pulse.
REQ-012 l1_type  out  NBIT  prescaled bits that caused the last trigger; held until the next trigger.
REQ-013 l1_cnt  out  CNTW  count of accepted triggers.
REQ-014 l1_busy  out  1  1 while FSM is not IDLE or busy_in=1.

Function
REQ-015 Stage 1 SHALL register ftd_in into ftd_q and ftd_q into ftd_qq; rising edge e[i] = ftd_q[i] & ~ftd_qq[i]; a held level yields one edge.
REQ-016 live SHALL be defined as (state==IDLE) & ~busy_in.
REQ-017 Per-bit prescale counter pc[i] (PSW bits) SHALL advance only when live & e[i] & mask[i] & prescale[i]!=0.
REQ-018 On an advancing cycle: if pc[i]+1 >= prescale[i], set psnm[i]=1 and pc[i]=0; otherwise pc[i]=pc[i]+1 and psnm[i]=0.
REQ-019 prescale[i]=1 SHALL fire on every counted edge; prescale[i]=0 or mask[i]=0 SHALL hold pc[i] and never fire.
REQ-020 Lowering prescale below the current pc[i] SHALL fire on the next counted edge (>= compare), with no lockup.
REQ-021 psnm SHALL be a registered vector, cleared on every cycle in which it is not set by REQ-018; edges arriving while not live are dropped, not queued.
REQ-022 FSM states IDLE, FIRE, DEAD; reset state IDLE.
REQ-023 IDLE -> FIRE when psnm!=0 & busy_in==0; l1_type <= psnm on that transition; if busy_in==1, psnm is discarded and the FSM stays IDLE.
REQ-024 FIRE: l1_trg=1 for exactly this one cycle; l1_cnt <= l1_cnt+1 (wraps all-ones -> 0); dead counter loaded with DEADTIME-1; -> DEAD.
REQ-025 DEAD: dead counter decrements; when it is 0 and busy_in==0 -> IDLE; when it is 0 and busy_in==1, stay in DEAD until busy_in==0.
REQ-026 l1_trg and l1_busy SHALL be registered outputs decoded from state (FIRE; not IDLE or busy_in).
REQ-027 Latency: when ftd_in rises and is sampled at clock edge N (block live, prescale 1), l1_trg SHALL be high in the cycle after edge N+3.
REQ-028 Several bits firing in one cycle SHALL produce one trigger, with all firing bits set in l1_type.

Reset
REQ-029 rstn=0 SHALL immediately and asynchronously clear: state=IDLE, l1_trg=0, l1_type=0, l1_cnt=0, l1_busy=0, all pc, psnm, ftd_q, ftd_qq and the dead counter.
REQ-030 After rstn deasserts, a ftd_in bit already high SHALL produce an edge (ftd_qq starts at 0).

Verification
REQ-031 mask=all 1s, all prescale=1, ftd_in[2] pulses high for 1 cycle -> single l1_trg at the REQ-027 latency, l1_type=0x0004, l1_cnt=1.
REQ-032 prescale[4]=3, six isolated 1-cycle edges on bit 4 spaced 20 cycles apart -> triggers on edges 3 and 6 only, l1_cnt=2.
REQ-033 DEADTIME=8, edges on bit 0 at cycles 0, 4 and 16 -> triggers on the edges at cycles 0 and 16; the edge at cycle 4 is dropped.
REQ-034 busy_in=1 throughout, 10 edges on bit 1 with prescale=2 -> no l1_trg, pc unchanged, l1_busy=1; busy_in released, next edge -> pc=1, no trigger yet.
REQ-035 CNTW=4, 17 accepted triggers -> l1_cnt sequence 1..15, 0, 1.
REQ-036 rstn pulsed low during DEAD -> all outputs 0 within the same cycle; after release, the next edge triggers normally.
